// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - register addresses and default parameters for the LED controller
package led_pkg;

   localparam logic [1:0] LED_ADDR_DATA   = 2'd0;
   localparam logic [1:0] LED_ADDR_BLINK  = 2'd1;
   localparam logic [1:0] LED_ADDR_PERIOD = 2'd2;
   localparam logic [1:0] LED_ADDR_DUTY   = 2'd3;

   localparam int          LED_DEF_N_LED       = 8;
   localparam int          LED_DEF_PWM_BITS    = 4;
   localparam int          LED_DEF_PERIOD_BITS = 24;
   localparam logic [31:0] LED_DEF_PERIOD      = 32'd12_500_000;

endpackage

// File: rtl/led_blink_timer.sv
// rtl/led_blink_timer.sv - blink half-period counter producing the blink phase
module led_blink_timer #(
   parameter int PERIOD_BITS = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   restart,
   input  logic [PERIOD_BITS-1:0] period,
   output logic                   phase
);

   localparam logic [PERIOD_BITS-1:0] CNT_ONE = PERIOD_BITS'(1);

   logic [PERIOD_BITS-1:0] r_cnt;
   logic                   r_phase;

   // A restart takes priority over the terminal count so a new period starts lit.
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         r_cnt   <= '0;
         r_phase <= 1'b1;
      end else if (r_cnt == period) begin
         r_cnt   <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_cnt   <= r_cnt + CNT_ONE;
      end
   end

   assign phase = r_phase;

endmodule

// File: rtl/led_ctrl.sv
// rtl/led_ctrl.sv - bus-mapped LED controller with per-LED blink and global PWM brightness
module led_ctrl
   import led_pkg::*;
#(
   parameter int                     N_LED       = LED_DEF_N_LED,
   parameter int                     PWM_BITS    = LED_DEF_PWM_BITS,
   parameter int                     PERIOD_BITS = LED_DEF_PERIOD_BITS,
   parameter logic [PERIOD_BITS-1:0] DEF_PERIOD  = PERIOD_BITS'(LED_DEF_PERIOD)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic [N_LED-1:0] led_out
);

   localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);

   logic [N_LED-1:0]       r_data;
   logic [N_LED-1:0]       r_blink;
   logic [PERIOD_BITS-1:0] r_period;
   logic [PWM_BITS-1:0]    r_duty;
   logic [PWM_BITS-1:0]    r_pwm_cnt;
   logic [N_LED-1:0]       r_led_out;

   logic w_wr;
   logic w_restart;
   logic w_phase;
   logic w_pwm_on;
   logic w_unused_wdata;

   assign w_wr      = ena && we;
   assign w_restart = w_wr && (addr == LED_ADDR_PERIOD);
   // Only the low bits of wdata land in the registers; the rest is accepted and dropped.
   assign w_unused_wdata = &{1'b0, wdata};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data   <= '0;
         r_blink  <= '0;
         r_period <= DEF_PERIOD;
         r_duty   <= '1;
      end else if (w_wr) begin
         case (addr)
            LED_ADDR_DATA:   r_data   <= wdata[N_LED-1:0];
            LED_ADDR_BLINK:  r_blink  <= wdata[N_LED-1:0];
            LED_ADDR_PERIOD: r_period <= wdata[PERIOD_BITS-1:0];
            default:         r_duty   <= wdata[PWM_BITS-1:0];
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      if (ena) begin
         case (addr)
            LED_ADDR_DATA:   rdata[N_LED-1:0]       = r_data;
            LED_ADDR_BLINK:  rdata[N_LED-1:0]       = r_blink;
            LED_ADDR_PERIOD: rdata[PERIOD_BITS-1:0] = r_period;
            default:         rdata[PWM_BITS-1:0]    = r_duty;
         endcase
      end
   end

   led_blink_timer #(
      .PERIOD_BITS (PERIOD_BITS)
   ) u_blink_timer (
      .clk     (clk),
      .rst     (rst),
      .restart (w_restart),
      .period  (r_period),
      .phase   (w_phase)
   );

   // All-ones duty is treated as continuously on rather than 15/16.
   assign w_pwm_on = (&r_duty) | (r_pwm_cnt < r_duty);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pwm_cnt <= '0;
         r_led_out <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
         r_led_out <= r_data & (~r_blink | {N_LED{w_phase}}) & {N_LED{w_pwm_on}};
      end
   end

   assign led_out = r_led_out;

endmodule
